// File: rtl/rmt_alu_pkg.sv
// Shared definitions for the RMT stateful ALU: opcodes, FSM states and
// the page-table entry layout.
package rmt_alu_pkg;

  localparam int unsigned OPCODE_W = 8;

  localparam logic [OPCODE_W-1:0] OP_ADD     = 8'h01;
  localparam logic [OPCODE_W-1:0] OP_SUB     = 8'h02;
  localparam logic [OPCODE_W-1:0] OP_RSUB    = 8'h03;
  localparam logic [OPCODE_W-1:0] OP_NEQ     = 8'h04;
  localparam logic [OPCODE_W-1:0] OP_NEQ_ALT = 8'h05;
  localparam logic [OPCODE_W-1:0] OP_EQ      = 8'h06;
  localparam logic [OPCODE_W-1:0] OP_LOADD   = 8'h07;
  localparam logic [OPCODE_W-1:0] OP_STORE   = 8'h08;
  localparam logic [OPCODE_W-1:0] OP_ADDI    = 8'h09;
  localparam logic [OPCODE_W-1:0] OP_SUBI    = 8'h0A;
  localparam logic [OPCODE_W-1:0] OP_LOAD    = 8'h0B;
  localparam logic [OPCODE_W-1:0] OP_WRAPINC = 8'h0C;
  localparam logic [OPCODE_W-1:0] OP_SATADD  = 8'h0D;
  localparam logic [OPCODE_W-1:0] OP_SET     = 8'h0E;
  localparam logic [OPCODE_W-1:0] OP_ITE     = 8'h10;
  localparam logic [OPCODE_W-1:0] OP_ITE_ALT = 8'h11;
  localparam logic [OPCODE_W-1:0] OP_LOR     = 8'h12;
  localparam logic [OPCODE_W-1:0] OP_LAND    = 8'h13;
  localparam logic [OPCODE_W-1:0] OP_NZ      = 8'h14;
  localparam logic [OPCODE_W-1:0] OP_EQ_ALT  = 8'h17;
  localparam logic [OPCODE_W-1:0] OP_GEQ     = 8'h18;
  localparam logic [OPCODE_W-1:0] OP_GEQ_ALT = 8'h1B;
  localparam logic [OPCODE_W-1:0] OP_LT      = 8'h1C;
  localparam logic [OPCODE_W-1:0] OP_LT_ALT  = 8'h1D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EX   = 2'd2,
    ST_OUT  = 2'd3
  } alu_state_e;

  // Page entry is {addr_len, base_addr}
  localparam int unsigned PG_FIELD_W  = 8;
  localparam int unsigned PG_BASE_LSB = 0;
  localparam int unsigned PG_LEN_LSB  = 8;

  // Opcodes that touch the state RAM and are therefore bounds-checked
  function automatic logic is_stateful(input logic [OPCODE_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_LOADD, OP_WRAPINC, OP_SATADD: r = 1'b1;
      default:                                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rmt_state_ram.sv
// Per-ALU state memory: simple dual-port, one write port and one registered
// read port. Contents are deliberately not reset.
module rmt_state_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/rmt_stateful_alu.sv
// Stateful ALU for one RMT action slot: computes a PHV container from four
// operands and optionally read-modify-writes a tenant-isolated state RAM.
module rmt_stateful_alu
  import rmt_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ACTION_LEN = 64,
  parameter int unsigned STAGE_ID   = 0,
  parameter int unsigned ACTION_ID  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  input  logic [DATA_WIDTH-1:0] operand_3_in,
  input  logic [DATA_WIDTH-1:0] operand_4_in,
  output logic                  ready_out,
  input  logic [15:0]           page_tbl_out,
  input  logic                  page_tbl_valid,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_valid,
  input  logic                  ready_in,
  output logic                  overflow_out
);

  localparam int unsigned CMP_W = (ADDR_WIDTH > PG_FIELD_W) ? ADDR_WIDTH : PG_FIELD_W;

  alu_state_e            state_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] container_q;
  logic                  cvalid_q;
  logic                  ovf_out_q;

  logic [OPCODE_W-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, c_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ovf_q;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [OPCODE_W-1:0]   op_c;
  logic [ADDR_WIDTH-1:0] offset_c;
  logic [PG_FIELD_W-1:0] base_c, len_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  ovf_c;

  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH:0]   sat_sum;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  wr_en_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  wea_c;
  logic                  rea_c;

  // Address translation and tenant bounds check on the incoming request
  assign op_c     = action_in[ACTION_LEN-1 -: OPCODE_W];
  assign offset_c = operand_2_in[ADDR_WIDTH-1:0];
  assign base_c   = page_tbl_out[PG_BASE_LSB +: PG_FIELD_W];
  assign len_c    = page_tbl_out[PG_LEN_LSB +: PG_FIELD_W];
  assign addr_c   = ADDR_WIDTH'(CMP_W'(base_c) + CMP_W'(offset_c));
  assign ovf_c    = is_stateful(op_c) &&
                    (!page_tbl_valid || (CMP_W'(offset_c) > CMP_W'(len_c)));

  // Write only on the result handshake; reset cancels a pending write
  assign wea_c = rst_n && (state_q == ST_OUT) && ready_in && wr_en_q;
  assign rea_c = (state_q == ST_RD);

  rmt_state_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_state_ram (
    .clk     (clk),
    .we_i    (wea_c),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .re_i    (rea_c),
    .raddr_i (addr_q),
    .rdata_o (ld_data)
  );

  // Result and write-back datapath, evaluated while in EX
  always_comb begin
    res_d   = c_q;
    wr_en_d = 1'b0;
    wdata_d = c_q;
    sat_sum = {1'b0, ld_data} + {1'b0, a_q};
    case (op_q)
      OP_ADD, OP_ADDI:    res_d = a_q + b_q;
      OP_SUB, OP_SUBI:    res_d = a_q - b_q;
      OP_RSUB:            res_d = b_q - a_q;
      OP_SET:             res_d = b_q;
      OP_NEQ, OP_NEQ_ALT: res_d = DATA_WIDTH'(a_q != b_q);
      OP_EQ, OP_EQ_ALT:   res_d = DATA_WIDTH'(a_q == b_q);
      OP_GEQ, OP_GEQ_ALT: res_d = DATA_WIDTH'(a_q >= b_q);
      OP_LT, OP_LT_ALT:   res_d = DATA_WIDTH'(a_q < b_q);
      OP_NZ:              res_d = DATA_WIDTH'(a_q != '0);
      OP_LAND:            res_d = DATA_WIDTH'((a_q != '0) && (b_q != '0));
      OP_LOR:             res_d = DATA_WIDTH'((a_q != '0) || (b_q != '0));
      OP_ITE, OP_ITE_ALT: res_d = (a_q != '0) ? b_q : c_q;
      OP_LOAD:            res_d = ld_data;
      OP_STORE: begin
        res_d   = c_q;
        wr_en_d = 1'b1;
        wdata_d = a_q;
      end
      OP_LOADD: begin
        res_d   = ld_data + DATA_WIDTH'(1);
        wr_en_d = 1'b1;
        wdata_d = res_d;
      end
      OP_WRAPINC: begin
        res_d   = (ld_data >= c_q) ? '0 : ld_data + DATA_WIDTH'(1);
        wr_en_d = 1'b1;
        wdata_d = res_d;
      end
      OP_SATADD: begin
        res_d   = (sat_sum > {1'b0, c_q}) ? c_q : sat_sum[DATA_WIDTH-1:0];
        wr_en_d = 1'b1;
        wdata_d = res_d;
      end
      default: ;
    endcase
    // Out-of-bounds access: passthrough C and suppress the write
    if (ovf_q) begin
      res_d   = c_q;
      wr_en_d = 1'b0;
    end
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      container_q <= '0;
      cvalid_q    <= 1'b0;
      ovf_out_q   <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      addr_q      <= '0;
      ovf_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (action_valid && ready_q) begin
            op_q    <= op_c;
            a_q     <= operand_1_in;
            b_q     <= operand_2_in;
            c_q     <= operand_3_in;
            addr_q  <= addr_c;
            ovf_q   <= ovf_c;
            ready_q <= 1'b0;
            state_q <= ST_RD;
          end
        end
        ST_RD: begin
          state_q <= ST_EX;
        end
        ST_EX: begin
          container_q <= res_d;
          ovf_out_q   <= ovf_q;
          wr_en_q     <= wr_en_d;
          wdata_q     <= wdata_d;
          cvalid_q    <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (ready_in) begin
            cvalid_q <= 1'b0;
            wr_en_q  <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_out       = ready_q;
  assign container_out   = container_q;
  assign container_valid = cvalid_q;
  assign overflow_out    = ovf_out_q;

  // Reserved operand, non-opcode action bits and informational IDs
  logic unused_inputs;
  assign unused_inputs = ^{operand_4_in, action_in[ACTION_LEN-OPCODE_W-1:0],
                           operand_2_in[DATA_WIDTH-1:ADDR_WIDTH],
                           32'(STAGE_ID), 32'(ACTION_ID)};

endmodule

// File: tb/tb_rmt_stateful_alu.sv
// Randomised scoreboard bench for rmt_stateful_alu with directed RAM,
// overflow, backpressure and mid-transaction reset scenarios.
module tb_rmt_stateful_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] action_in = '0;
  logic        action_valid = 1'b0;
  logic [31:0] operand_1_in = '0, operand_2_in = '0, operand_3_in = '0, operand_4_in = '0;
  logic        ready_out;
  logic [15:0] page_tbl_out = '0;
  logic        page_tbl_valid = 1'b0;
  logic [31:0] container_out;
  logic        container_valid;
  logic        ready_in = 1'b1;
  logic        overflow_out;

  rmt_stateful_alu #(
    .DATA_WIDTH (32), .ADDR_WIDTH (5), .ACTION_LEN (64), .STAGE_ID (0), .ACTION_ID (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .action_in       (action_in),
    .action_valid    (action_valid),
    .operand_1_in    (operand_1_in),
    .operand_2_in    (operand_2_in),
    .operand_3_in    (operand_3_in),
    .operand_4_in    (operand_4_in),
    .ready_out       (ready_out),
    .page_tbl_out    (page_tbl_out),
    .page_tbl_valid  (page_tbl_valid),
    .container_out   (container_out),
    .container_valid (container_valid),
    .ready_in        (ready_in),
    .overflow_out    (overflow_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q [$];
  int   acc_cyc = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [31:0] ram_m [32];
  logic [7:0] op_list [$] = '{8'h01, 8'h09, 8'h02, 8'h0A, 8'h03, 8'h0E, 8'h04, 8'h05,
                             8'h06, 8'h17, 8'h18, 8'h1B, 8'h1C, 8'h1D, 8'h14, 8'h13,
                             8'h12, 8'h10, 8'h11, 8'h0B, 8'h08, 8'h07, 8'h0C, 8'h0D,
                             8'h00, 8'h3F};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: applies the opcode rules directly to the RAM image
  function automatic void model(input logic [7:0] op, input logic [31:0] a, b, c,
                                input logic [7:0] base, len, input logic pv,
                                output logic [31:0] out, output logic ovf);
    int unsigned off, addr;
    logic [31:0] l;
    longint unsigned s;
    bit stateful;
    off  = b % 32;
    addr = (base + off) % 32;
    l    = ram_m[addr];
    stateful = op inside {8'h0B, 8'h08, 8'h07, 8'h0C, 8'h0D};
    ovf  = stateful && (!pv || off > len);
    out  = c;
    if (ovf) return;
    case (op)
      8'h01, 8'h09: out = a + b;
      8'h02, 8'h0A: out = a - b;
      8'h03:        out = b - a;
      8'h0E:        out = b;
      8'h04, 8'h05: out = (a != b) ? 1 : 0;
      8'h06, 8'h17: out = (a == b) ? 1 : 0;
      8'h18, 8'h1B: out = (a >= b) ? 1 : 0;
      8'h1C, 8'h1D: out = (a < b) ? 1 : 0;
      8'h14:        out = (a != 0) ? 1 : 0;
      8'h13:        out = (a != 0 && b != 0) ? 1 : 0;
      8'h12:        out = (a != 0 || b != 0) ? 1 : 0;
      8'h10, 8'h11: out = (a != 0) ? b : c;
      8'h0B:        out = l;
      8'h08: begin out = c; ram_m[addr] = a; end
      8'h07: begin out = l + 1; ram_m[addr] = out; end
      8'h0C: begin out = (l >= c) ? 0 : l + 1; ram_m[addr] = out; end
      8'h0D: begin
        s = longint'(l) + longint'(a);
        out = (s > c) ? c : 32'(s);
        ram_m[addr] = out;
      end
      default: out = c;
    endcase
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accept edge
  task automatic issue(input logic [7:0] op, input logic [31:0] a, b, c,
                       input logic [7:0] base, len, input logic pv, input bit track);
    logic [31:0] eo;
    logic        ev;
    int w = 0;
    while (ready_out !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++;
    if (ready_out !== 1'b1) begin
      n_errors++;
      $display("FAIL issue_wait: ready_out=%b expected 1 within 100 cycles", ready_out);
      return;
    end
    action_in      = {op, $urandom(), 24'($urandom())};
    operand_1_in   = a;
    operand_2_in   = b;
    operand_3_in   = c;
    operand_4_in   = $urandom();
    page_tbl_out   = {len, base};
    page_tbl_valid = pv;
    action_valid   = 1'b1;
    if (track) begin
      model(op, a, b, c, base, len, pv, eo, ev);
      exp_q.push_back({ev, eo});
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    action_valid   = 1'b0;
    page_tbl_valid = $urandom_range(0, 1);
    operand_1_in   = $urandom();
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || ready_out !== 1'b1) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Single owner of ready_in
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       ready_in = ($urandom_range(0, 2) != 0);
        2:       ready_in = 1'b0;
        default: ready_in = 1'b1;
      endcase
    end
  end

  // Monitor: latency, stability under stall, busy flag and scoreboard compare
  logic        prev_cv = 1'b0;
  logic [31:0] prev_out = '0;
  logic        prev_ovf = 1'b0;
  logic [32:0] exp_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cv = 1'b0;
    end else begin
      if (container_valid) begin
        check("busy_ready_out", 32'(ready_out), 32'd0);
        if (!prev_cv) begin
          check("latency", 32'(cyc - acc_cyc), 32'd3);
        end else begin
          check("stall_data", container_out, prev_out);
          check("stall_ovf", 32'(overflow_out), 32'(prev_ovf));
        end
        if (ready_in) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_result: got 0x%0h with no pending expectation", container_out);
          end else begin
            exp_e = exp_q.pop_front();
            check("container_out", container_out, exp_e[31:0]);
            check("overflow_out", 32'(overflow_out), 32'(exp_e[32]));
          end
        end
      end
      prev_cv  = container_valid;
      prev_out = container_out;
      prev_ovf = overflow_out;
    end
  end

  logic [7:0]  rop;
  logic [31:0] ra, rb, rc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_ready", 32'(ready_out), 32'd1);
    check("rst_hold_valid", 32'(container_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_ready_out", 32'(ready_out), 32'd1);
    check("reset_container_out", container_out, 32'd0);
    check("reset_container_valid", 32'(container_valid), 32'd0);
    check("reset_overflow_out", 32'(overflow_out), 32'd0);

    // Known RAM image
    for (int i = 0; i < 32; i++) issue(8'h08, $urandom(), 32'(i), $urandom(), 8'd0, 8'd255, 1'b1, 1'b1);

    // Basic ADD
    issue(8'h01, 32'd5, 32'd7, 32'h1234, 8'd0, 8'd31, 1'b1, 1'b1);

    // Store then load through a page: RAM[7]
    issue(8'h08, 32'hAB, 32'd3, 32'h55, 8'd4, 8'd8, 1'b1, 1'b1);
    issue(8'h0B, 32'h0, 32'd3, 32'h66, 8'd4, 8'd8, 1'b1, 1'b1);

    // Wrapping counter: 1, 2, 0, 1
    issue(8'h08, 32'd0, 32'd2, 32'd0, 8'd16, 8'd8, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) issue(8'h0C, $urandom(), 32'd2, 32'd2, 8'd16, 8'd8, 1'b1, 1'b1);

    // Out-of-bounds LOADD, offset at the limit, invalid page entry
    issue(8'h07, 32'd1, 32'd9, 32'hC0FFEE, 8'd0, 8'd8, 1'b1, 1'b1);
    issue(8'h0B, 32'd0, 32'd9, 32'h1, 8'd0, 8'd20, 1'b1, 1'b1);
    issue(8'h0B, 32'd0, 32'd8, 32'h2, 8'd0, 8'd8, 1'b1, 1'b1);
    issue(8'h08, 32'hDEAD, 32'd1, 32'h3, 8'd0, 8'd8, 1'b0, 1'b1);
    issue(8'h01, 32'd3, 32'd4, 32'h4, 8'd0, 8'd0, 1'b0, 1'b1);
    issue(8'h0B, 32'd0, 32'd1, 32'h5, 8'd0, 8'd8, 1'b1, 1'b1);

    // Saturating add held under backpressure for 10 cycles
    issue(8'h08, 32'd250, 32'd5, 32'd0, 8'd20, 8'd10, 1'b1, 1'b1);
    drain();
    ready_mode = 2;
    @(posedge clk); #1;
    issue(8'h0D, 32'd10, 32'd5, 32'd255, 8'd20, 8'd10, 1'b1, 1'b1);
    begin
      int w = 0;
      while (container_valid !== 1'b1 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      check("stall_valid_seen", 32'(container_valid), 32'd1);
    end
    repeat (10) @(posedge clk);
    #1;
    check("stall_still_valid", 32'(container_valid), 32'd1);
    ready_mode = 0;
    issue(8'h0B, 32'd0, 32'd5, 32'd0, 8'd20, 8'd10, 1'b1, 1'b1);
    drain();

    // Reset during EX of a STORE: write must be cancelled
    issue(8'h08, 32'h5A5A, 32'd6, 32'd0, 8'd0, 8'd31, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_out", 32'(ready_out), 32'd1);
    check("midrst_valid", 32'(container_valid), 32'd0);
    issue(8'h0B, 32'd0, 32'd6, 32'd0, 8'd0, 8'd31, 1'b1, 1'b1);
    drain();

    // Randomised traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 250; i++) begin
      rop = op_list[$urandom_range(0, op_list.size() - 1)];
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      rc  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      issue(rop, ra, rb, rc, 8'($urandom()), 8'($urandom_range(0, 40)),
            ($urandom_range(0, 7) != 0), 1'b1);
    end
    ready_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
